// File: rtl/jogo_pkg.sv
// Shared definitions for the naval-battle game sequencer: state encoding,
// mode request codes and default game parameters.
package jogo_pkg;

  typedef enum logic [2:0] {
    DESLIGADO  = 3'd0,
    PREPARACAO = 3'd1,
    ATAQUE     = 3'd2,
    AGUARDA    = 3'd3,
    VITORIA    = 3'd4,
    DERROTA    = 3'd5
  } estado_t;

  // {ch7,ch6} mode switch codes; both 00 and 11 mean "off"
  localparam logic [1:0] MODO_OFF     = 2'b00;
  localparam logic [1:0] MODO_PREP    = 2'b01;
  localparam logic [1:0] MODO_ATAQUE  = 2'b10;
  localparam logic [1:0] MODO_OFF_ALT = 2'b11;

  localparam int VIDAS_INICIAIS_PADRAO = 3;
  localparam int ALVOS_PADRAO          = 7;
  localparam int TIMEOUT_PADRAO        = 16;
  localparam int DIV_PISCA_PADRAO      = 4;

  localparam logic [5:0] TIROS_MAX = 6'd63;

  function automatic logic pedido_desligar(input logic [1:0] modo);
    return (modo == MODO_OFF) || (modo == MODO_OFF_ALT);
  endfunction

endpackage

// File: rtl/controlador_jogo_temporizador_disparo.sv
// Loadable up-counter that stops at a limit and flags expiry. Used as the
// shot-verdict timeout and, reloaded on every expiry, as the blink divider.
module temporizador_disparo #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         carregar,
  input  logic [W-1:0] limite,
  output logic         expirou
);

  logic [W-1:0] contagem;

  assign expirou = (contagem == limite);

  // Restart from zero on load, otherwise count up and hold at the limit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contagem <= '0;
    end else if (carregar) begin
      contagem <= '0;
    end else if (!expirou) begin
      contagem <= contagem + W'(1);
    end
  end

endmodule

// File: rtl/controlador_jogo.sv
// Central game sequencer: gates map loading, issues one shot request per
// confirmed attack, waits for the attack manager's verdict, owns the lives,
// hit and shot counters and declares win or loss.
//
// Handshake: confirmar is a one-cycle pulse sampled on the clock edge; the
// resulting carregar_mapa or disparo_req is a registered one-cycle pulse in
// the following cycle. After disparo_req the block holds ocupado until a
// one-cycle res_valido strobe (res_acerto/res_repetido qualified by it) or
// until the timeout expires; no new shot is accepted while ocupado is high.
module controlador_jogo
  import jogo_pkg::*;
#(
  parameter int VIDAS_INICIAIS = VIDAS_INICIAIS_PADRAO,
  parameter int ALVOS          = ALVOS_PADRAO,
  parameter int TIMEOUT        = TIMEOUT_PADRAO,
  parameter int DIV_PISCA      = DIV_PISCA_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] modo_req,
  input  logic       confirmar,
  input  logic       mapa_valido,
  input  logic       res_valido,
  input  logic       res_acerto,
  input  logic       res_repetido,
  output logic       desligado,
  output logic       preparacao,
  output logic       ataque,
  output logic       vitoria,
  output logic       derrota,
  output logic       carregar_mapa,
  output logic       disparo_req,
  output logic       ocupado,
  output logic       erro_timeout,
  output logic [1:0] vida,
  output logic [3:0] acertos,
  output logic [5:0] tiros,
  output logic       ligar_matriz,
  output logic       piscar
);

  estado_t    estado, estado_prox, destino;
  logic [1:0] vida_prox;
  logic [3:0] acertos_prox;
  logic [5:0] tiros_prox;
  logic       mapa_carregado, mapa_prox;
  logic       erro_prox, carregar_prox, disparo_prox, piscar_prox;
  logic       contou, contou_prox;      // last shot actually incremented tiros
  logic       carrega_timer, timer_expirou;
  logic       fim, fim_prox;
  logic       pisca_expirou, pisca_carregar;

  assign fim            = (estado == VITORIA) || (estado == DERROTA);
  assign fim_prox       = (estado_prox == VITORIA) || (estado_prox == DERROTA);
  assign pisca_carregar = pisca_expirou || !fim;

  temporizador_disparo #(.W(8)) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .carregar (carrega_timer),
    .limite   (8'(TIMEOUT - 1)),
    .expirou  (timer_expirou)
  );

  temporizador_disparo #(.W(DIV_PISCA)) u_pisca (
    .clock    (clock),
    .reset    (reset),
    .carregar (pisca_carregar),
    .limite   ({DIV_PISCA{1'b1}}),
    .expirou  (pisca_expirou)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= DESLIGADO;
    else       estado <= estado_prox;
  end

  // Next state, counter updates and pulse requests
  always_comb begin
    estado_prox   = estado;
    vida_prox     = vida;
    acertos_prox  = acertos;
    tiros_prox    = tiros;
    mapa_prox     = mapa_carregado;
    erro_prox     = erro_timeout;
    contou_prox   = contou;
    carregar_prox = 1'b0;
    disparo_prox  = 1'b0;
    carrega_timer = 1'b0;
    // A pending return to preparation is honoured once the shot resolves
    destino       = (modo_req == MODO_PREP) ? PREPARACAO : ATAQUE;

    if (pedido_desligar(modo_req)) begin
      // Off wins over everything, including a verdict in the same cycle
      estado_prox  = DESLIGADO;
      vida_prox    = 2'd0;
      acertos_prox = 4'd0;
      tiros_prox   = 6'd0;
      mapa_prox    = 1'b0;
    end else begin
      case (estado)
        DESLIGADO: begin
          if (modo_req == MODO_PREP) begin
            estado_prox = PREPARACAO;
            vida_prox   = 2'(VIDAS_INICIAIS);
          end
        end
        PREPARACAO: begin
          if (confirmar && mapa_valido) begin
            carregar_prox = 1'b1;
            mapa_prox     = 1'b1;
          end
          if ((modo_req == MODO_ATAQUE) && mapa_carregado) estado_prox = ATAQUE;
        end
        ATAQUE: begin
          if (modo_req == MODO_PREP) begin
            estado_prox = PREPARACAO;
          end else if (confirmar) begin
            disparo_prox  = 1'b1;
            erro_prox     = 1'b0;
            carrega_timer = 1'b1;
            estado_prox   = AGUARDA;
            contou_prox   = (tiros != TIROS_MAX);
            if (tiros != TIROS_MAX) tiros_prox = tiros + 6'd1;
          end
        end
        AGUARDA: begin
          if (res_valido) begin
            if (res_repetido) begin
              // A repeated cell costs nothing: undo the shot count
              if (contou) tiros_prox = tiros - 6'd1;
              estado_prox = destino;
            end else if (res_acerto) begin
              acertos_prox = acertos + 4'd1;
              estado_prox  = (acertos_prox == 4'(ALVOS)) ? VITORIA : destino;
            end else begin
              if (vida != 2'd0) vida_prox = vida - 2'd1;
              estado_prox = (vida_prox == 2'd0) ? DERROTA : destino;
            end
          end else if (timer_expirou) begin
            erro_prox   = 1'b1;
            estado_prox = destino;
          end
        end
        VITORIA, DERROTA: begin
          estado_prox = estado;
        end
        default: begin
          estado_prox = DESLIGADO;
        end
      endcase
    end

    // Blink phase restarts low on entering an end state
    piscar_prox = fim_prox && fim && (piscar ^ pisca_expirou);
  end

  // Counters, flags and registered pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vida           <= 2'd0;
      acertos        <= 4'd0;
      tiros          <= 6'd0;
      mapa_carregado <= 1'b0;
      erro_timeout   <= 1'b0;
      contou         <= 1'b0;
      carregar_mapa  <= 1'b0;
      disparo_req    <= 1'b0;
      piscar         <= 1'b0;
    end else begin
      vida           <= vida_prox;
      acertos        <= acertos_prox;
      tiros          <= tiros_prox;
      mapa_carregado <= mapa_prox;
      erro_timeout   <= erro_prox;
      contou         <= contou_prox;
      carregar_mapa  <= carregar_prox;
      disparo_req    <= disparo_prox;
      piscar         <= piscar_prox;
    end
  end

  assign desligado    = (estado == DESLIGADO);
  assign preparacao   = (estado == PREPARACAO);
  assign ataque       = (estado == ATAQUE) || (estado == AGUARDA);
  assign vitoria      = (estado == VITORIA);
  assign derrota      = (estado == DERROTA);
  assign ocupado      = (estado == AGUARDA);
  assign ligar_matriz = (preparacao || ataque) && (vida != 2'd0);

endmodule

// File: tb/tb_controlador_jogo.sv
// Bench for controlador_jogo: directed game scenarios plus randomized games,
// checked against a shot-level model of the game rules.
module tb_controlador_jogo;

  localparam int VIDAS   = 3;
  localparam int ALVOS   = 7;
  localparam int TIMEOUT = 16;
  localparam int DIV     = 4;

  localparam logic [1:0] M_OFF_C  = 2'b00;
  localparam logic [1:0] M_PREP_C = 2'b01;
  localparam logic [1:0] M_ATQ_C  = 2'b10;

  logic       clock, reset;
  logic [1:0] modo_req;
  logic       confirmar, mapa_valido, res_valido, res_acerto, res_repetido;
  logic       desligado, preparacao, ataque, vitoria, derrota;
  logic       carregar_mapa, disparo_req, ocupado, erro_timeout;
  logic [1:0] vida;
  logic [3:0] acertos;
  logic [5:0] tiros;
  logic       ligar_matriz, piscar;

  int n_chk  = 0;
  int n_pass = 0;

  // Shot-level model of the game
  typedef enum int {S_OFF, S_PREP, S_ATQ, S_VIT, S_DER} m_estado_t;
  m_estado_t m_st;
  int        m_vida, m_acertos, m_tiros;
  bit        m_erro;

  controlador_jogo #(
    .VIDAS_INICIAIS(VIDAS), .ALVOS(ALVOS), .TIMEOUT(TIMEOUT), .DIV_PISCA(DIV)
  ) dut (
    .clock(clock), .reset(reset), .modo_req(modo_req), .confirmar(confirmar),
    .mapa_valido(mapa_valido), .res_valido(res_valido), .res_acerto(res_acerto),
    .res_repetido(res_repetido), .desligado(desligado), .preparacao(preparacao),
    .ataque(ataque), .vitoria(vitoria), .derrota(derrota),
    .carregar_mapa(carregar_mapa), .disparo_req(disparo_req), .ocupado(ocupado),
    .erro_timeout(erro_timeout), .vida(vida), .acertos(acertos), .tiros(tiros),
    .ligar_matriz(ligar_matriz), .piscar(piscar)
  );

  // Clock and watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [4:0] flags_de(input m_estado_t s);
    case (s)
      S_OFF:   return 5'b10000;
      S_PREP:  return 5'b01000;
      S_ATQ:   return 5'b00100;
      S_VIT:   return 5'b00010;
      default: return 5'b00001;
    endcase
  endfunction

  task automatic check_all(input string tag);
    logic exp_ligar;
    exp_ligar = ((m_st == S_PREP) || (m_st == S_ATQ)) && (m_vida != 0);
    chk({tag, "/flags"}, 8'({desligado, preparacao, ataque, vitoria, derrota}), 8'(flags_de(m_st)));
    chk({tag, "/vida"}, 8'(vida), 8'(m_vida));
    chk({tag, "/acertos"}, 8'(acertos), 8'(m_acertos));
    chk({tag, "/tiros"}, 8'(tiros), 8'(m_tiros));
    chk({tag, "/erro_timeout"}, 8'(erro_timeout), 8'(m_erro));
    chk({tag, "/ligar_matriz"}, 8'(ligar_matriz), 8'(exp_ligar));
    chk({tag, "/ocupado"}, 8'(ocupado), 8'd0);
    if (m_st != S_VIT && m_st != S_DER) chk({tag, "/piscar"}, 8'(piscar), 8'd0);
  endtask

  task automatic model_off();
    m_st = S_OFF; m_vida = 0; m_acertos = 0; m_tiros = 0;
  endtask

  // Power the game off, enter preparation, load a map and go to attack
  task automatic start_game(input string tag);
    modo_req = M_OFF_C; tick();
    model_off();
    check_all({tag, "/off"});
    modo_req = M_PREP_C; tick();
    m_st = S_PREP; m_vida = VIDAS;
    check_all({tag, "/prep"});
    mapa_valido = 1'b1; confirmar = 1'b1; tick(); confirmar = 1'b0;
    chk({tag, "/carregar_pulse"}, 8'(carregar_mapa), 8'd1);
    modo_req = M_ATQ_C; tick();
    chk({tag, "/carregar_end"}, 8'(carregar_mapa), 8'd0);
    m_st = S_ATQ;
    check_all({tag, "/atq"});
  endtask

  // One shot: kind 0 miss, 1 hit, 2 repeated, 3 no verdict (timeout).
  // volta asks for preparation while the verdict is pending.
  task automatic tiro(input string tag, input int kind, input bit volta);
    int  espera;
    bit  contou;
    confirmar = 1'b1; tick(); confirmar = 1'b0;
    contou = (m_tiros < 63);
    if (contou) m_tiros++;
    m_erro = 1'b0;
    chk({tag, "/disparo_req"}, 8'(disparo_req), 8'd1);
    chk({tag, "/ocupado"}, 8'(ocupado), 8'd1);
    chk({tag, "/erro_clear"}, 8'(erro_timeout), 8'd0);
    if (volta) modo_req = M_PREP_C;
    if (kind == 3) begin
      repeat (TIMEOUT - 1) tick();
      chk({tag, "/still_waiting"}, 8'(ocupado), 8'd1);
      tick();
      m_erro = 1'b1;
      m_st = volta ? S_PREP : S_ATQ;
    end else begin
      espera = $urandom_range(0, 4);
      for (int i = 0; i < espera; i++) begin
        confirmar = 1'($urandom_range(0, 1)); tick(); confirmar = 1'b0;
        chk({tag, "/no_extra_disparo"}, 8'(disparo_req), 8'd0);
        chk({tag, "/ocupado_wait"}, 8'(ocupado), 8'd1);
      end
      res_valido   = 1'b1;
      res_repetido = (kind == 2);
      res_acerto   = (kind == 1) ? 1'b1 : (kind == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      res_valido = 1'b0; res_repetido = 1'b0; res_acerto = 1'b0;
      m_st = volta ? S_PREP : S_ATQ;
      if (kind == 2) begin
        if (contou) m_tiros--;
      end else if (kind == 1) begin
        m_acertos++;
        if (m_acertos == ALVOS) m_st = S_VIT;
      end else begin
        m_vida--;
        if (m_vida == 0) m_st = S_DER;
      end
    end
    check_all(tag);
    if (volta) begin
      modo_req = M_ATQ_C; tick();
      if (m_st == S_PREP) m_st = S_ATQ;
      check_all({tag, "/back"});
    end
  endtask

  int seq[$];

  initial begin
    reset = 1'b1; modo_req = M_OFF_C; confirmar = 1'b0; mapa_valido = 1'b0;
    res_valido = 1'b0; res_acerto = 1'b0; res_repetido = 1'b0;
    model_off(); m_erro = 1'b0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    reset = 1'b0;
    modo_req = M_ATQ_C; tick();
    check_all("off_attack_req_ignored");

    // Preparation: invalid map is ignored and attack stays locked
    modo_req = M_PREP_C; tick();
    m_st = S_PREP; m_vida = VIDAS;
    check_all("prep_enter");
    mapa_valido = 1'b0; confirmar = 1'b1; tick(); confirmar = 1'b0;
    chk("invalid_map_no_load", 8'(carregar_mapa), 8'd0);
    modo_req = M_ATQ_C; tick(); tick();
    check_all("attack_locked_without_map");
    modo_req = M_PREP_C; mapa_valido = 1'b1; confirmar = 1'b1; tick(); confirmar = 1'b0;
    chk("valid_map_load", 8'(carregar_mapa), 8'd1);
    tick();
    chk("load_single_pulse", 8'(carregar_mapa), 8'd0);
    modo_req = M_ATQ_C; tick();
    m_st = S_ATQ;
    check_all("attack_enter");

    // Asynchronous reset in the middle of a pending shot
    confirmar = 1'b1; tick(); confirmar = 1'b0;
    chk("pre_reset_ocupado", 8'(ocupado), 8'd1);
    #2 reset = 1'b1;
    #1;
    model_off(); m_erro = 1'b0;
    check_all("async_reset");
    chk("async_reset_disparo", 8'(disparo_req), 8'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Defeat by three misses
    start_game("g1");
    for (int i = 0; i < 3; i++) tiro("miss", 0, 1'b0);
    confirmar = 1'b1; res_valido = 1'b1; tick(); confirmar = 1'b0; res_valido = 1'b0;
    chk("defeat_no_disparo", 8'(disparo_req), 8'd0);
    check_all("defeat_hold");

    // Victory: seven hits with two repeated cells interleaved
    start_game("g2");
    seq.delete();
    for (int i = 0; i < ALVOS; i++) seq.push_back(1);
    for (int i = 0; i < 2; i++) seq.insert($urandom_range(0, seq.size() - 1), 2);
    foreach (seq[i]) tiro("win_seq", seq[i], 1'b0);
    chk("victory_tiros", 8'(tiros), 8'd7);
    for (int k = 0; k < 4 * (1 << DIV); k++) begin
      if (k > 0) begin
        confirmar = 1'($urandom_range(0, 1)); res_valido = 1'($urandom_range(0, 1));
        res_acerto = 1'($urandom_range(0, 1));
        tick();
        confirmar = 1'b0; res_valido = 1'b0; res_acerto = 1'b0;
      end
      chk("piscar_phase", 8'(piscar), 8'((k >> DIV) & 1));
    end
    chk("victory_no_disparo", 8'(disparo_req), 8'd0);
    check_all("victory_hold");

    // Timeout, then the next shot clears the error
    start_game("g3");
    tiro("timeout", 3, 1'b0);
    tiro("after_timeout_hit", 1, 1'b0);
    tiro("miss_a", 0, 1'b0);
    tiro("miss_b", 0, 1'b0);

    // Off request arriving together with a losing verdict
    confirmar = 1'b1; tick(); confirmar = 1'b0;
    m_tiros++; m_erro = 1'b0;
    modo_req = M_OFF_C; res_valido = 1'b1; res_acerto = 1'b0; res_repetido = 1'b0;
    tick();
    res_valido = 1'b0;
    model_off();
    check_all("off_beats_verdict");

    // Randomized games with occasional excursions to preparation
    for (int g = 0; g < 4; g++) begin
      start_game("rnd_start");
      for (int s = 0; s < 20 && m_st == S_ATQ; s++) begin
        int r;
        int kind;
        r = $urandom_range(0, 9);
        kind = (r < 4) ? 1 : (r < 6) ? 0 : (r < 9) ? 2 : 3;
        tiro("rnd_shot", kind, ($urandom_range(0, 5) == 0));
        if (m_st == S_ATQ && $urandom_range(0, 7) == 0) begin
          modo_req = M_PREP_C; tick();
          m_st = S_PREP;
          check_all("rnd_to_prep");
          modo_req = M_ATQ_C; tick();
          m_st = S_ATQ;
          check_all("rnd_from_prep");
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
